// File: rtl/i2c_rf_arbiter_pkg.sv
// Shared types and constants for the I2C register-file access arbiter.
package i2c_rf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [31:0] BASE_ADDR = 32'hA000_B000;
  localparam int          NUM_REGS  = 4;

  // Register offsets from BASE_ADDR
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_FREQ   = 2'd2;
  localparam logic [1:0] REG_S0_ADR = 2'd3;

endpackage

// File: rtl/i2c_rf_arbiter_if.sv
// Bundle of the two master request ports and the register-file port.
interface i2c_rf_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32
);

  logic                  m0_req;
  logic                  m0_wr;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_ack;
  logic                  m0_err;
  logic [DATA_WIDTH-1:0] m0_rdata;

  logic                  m1_req;
  logic                  m1_wr;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_ack;
  logic                  m1_err;
  logic [DATA_WIDTH-1:0] m1_rdata;

  logic                  rf_valid;
  logic                  rf_wr_en;
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic [DATA_WIDTH-1:0] rf_rdata;

  // Arbiter side: takes requests, drives acks and the register-file strobe
  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wdata,
    output m0_ack, m0_err, m0_rdata,
    input  m1_req, m1_wr, m1_addr, m1_wdata,
    output m1_ack, m1_err, m1_rdata,
    output rf_valid, rf_wr_en, rf_addr, rf_wdata,
    input  rf_rdata
  );

  // Environment side: masters plus the register file
  modport master (
    output m0_req, m0_wr, m0_addr, m0_wdata,
    input  m0_ack, m0_err, m0_rdata,
    output m1_req, m1_wr, m1_addr, m1_wdata,
    input  m1_ack, m1_err, m1_rdata,
    input  rf_valid, rf_wr_en, rf_addr, rf_wdata,
    output rf_rdata
  );

endinterface

// File: rtl/i2c_rf_arbiter_arb2.sv
// Two-way round-robin picker: on a tie the master that did not win last time wins.
module i2c_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o,
  output logic       valid_o
);

  // Pick a one-hot winner; last_grant_i=1 means m1 won last, so m0 wins a tie
  always_comb begin
    gnt_o   = 2'b00;
    valid_o = |req_i;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_grant_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/i2c_rf_arbiter.sv
// Round-robin access controller between the host bus (m0) and the I2C engine (m1)
// for the I2C register file. One access in flight at a time; out-of-window
// addresses complete immediately with err.
module i2c_rf_arbiter
  import i2c_rf_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(i2c_rf_pkg::BASE_ADDR),
  parameter int                    NUM_REGS   = i2c_rf_pkg::NUM_REGS
) (
  input  logic             clk,
  input  logic             rst_n,
  i2c_rf_arbiter_if.slave  bus
);

  state_t                state_q;
  logic                  last_grant_q;
  logic                  owner_q;
  logic                  m0_ack_q, m1_ack_q;
  logic                  m0_err_q, m1_err_q;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m1_rdata_q;
  logic                  rf_valid_q;
  logic                  rf_wr_en_q;
  logic [ADDR_WIDTH-1:0] rf_addr_q;
  logic [DATA_WIDTH-1:0] rf_wdata_q;

  logic [1:0]            elig_d;
  logic [1:0]            gnt_oh;
  logic                  gnt_valid;
  logic                  winner_d;
  logic                  sel_wr_d;
  logic [ADDR_WIDTH-1:0] sel_addr_d;
  logic [ADDR_WIDTH-1:0] sel_off_d;
  logic [DATA_WIDTH-1:0] sel_wdata_d;
  logic                  sel_in_win_d;

  // A master whose ack is high this cycle is still dropping req, so it is masked out
  assign elig_d = {bus.m1_req & ~m1_ack_q, bus.m0_req & ~m0_ack_q};

  i2c_rr_arb2 u_arb (
    .req_i        (elig_d),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt_oh),
    .valid_o      (gnt_valid)
  );

  // Route the winner's request fields and decode whether it hits the register window
  always_comb begin
    winner_d    = (gnt_oh == 2'b10);
    sel_wr_d    = bus.m0_wr;
    sel_addr_d  = bus.m0_addr;
    sel_wdata_d = bus.m0_wdata;
    if (winner_d) begin
      sel_wr_d    = bus.m1_wr;
      sel_addr_d  = bus.m1_addr;
      sel_wdata_d = bus.m1_wdata;
    end
    sel_off_d    = sel_addr_d - BASE_ADDR;
    sel_in_win_d = (sel_addr_d >= BASE_ADDR) && (sel_off_d < ADDR_WIDTH'(NUM_REGS));
  end

  // Access FSM with all outputs registered; acks and rf_valid are single-cycle pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      rf_valid_q   <= 1'b0;
      rf_wr_en_q   <= 1'b0;
      rf_addr_q    <= '0;
      rf_wdata_q   <= '0;
    end else begin
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      rf_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            last_grant_q <= winner_d;
            if (sel_in_win_d) begin
              owner_q    <= winner_d;
              rf_valid_q <= 1'b1;
              rf_wr_en_q <= sel_wr_d;
              rf_addr_q  <= sel_addr_d;
              rf_wdata_q <= sel_wdata_d;
              state_q    <= ISSUE;
            end else if (winner_d) begin
              m1_ack_q <= 1'b1;
              m1_err_q <= 1'b1;
            end else begin
              m0_ack_q <= 1'b1;
              m0_err_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          state_q <= WAIT;
        end
        WAIT: begin
          state_q <= IDLE;
          if (owner_q) begin
            m1_ack_q <= 1'b1;
            m1_err_q <= 1'b0;
            if (!rf_wr_en_q) m1_rdata_q <= bus.rf_rdata;
          end else begin
            m0_ack_q <= 1'b1;
            m0_err_q <= 1'b0;
            if (!rf_wr_en_q) m0_rdata_q <= bus.rf_rdata;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.m0_ack   = m0_ack_q;
  assign bus.m0_err   = m0_err_q;
  assign bus.m0_rdata = m0_rdata_q;
  assign bus.m1_ack   = m1_ack_q;
  assign bus.m1_err   = m1_err_q;
  assign bus.m1_rdata = m1_rdata_q;
  assign bus.rf_valid = rf_valid_q;
  assign bus.rf_wr_en = rf_wr_en_q;
  assign bus.rf_addr  = rf_addr_q;
  assign bus.rf_wdata = rf_wdata_q;

endmodule
